// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// ALU operation codes and datapath mux select values.
package riscv_ctrl_pkg;

    // Major opcodes (Instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Controller states
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALRADR  = 4'd11,
        JALRPC   = 4'd12,
        LUI      = 4'd13,
        HALT     = 4'd14
    } ctrlState_e;

    // ALU operations
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // ALUOp classes handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // Result mux
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    // ALU A / B operand muxes
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Immediate format implied by the opcode; unknown opcodes fall back to I.
    function automatic logic [2:0] immSrcFor(input logic [6:0] opcode);
        case (opcode)
            OP_STORE:         return IMM_S;
            OP_BRANCH:        return IMM_B;
            OP_LUI, OP_AUIPC: return IMM_U;
            OP_JAL:           return IMM_J;
            default:          return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// ALU operation decode: fixed add, branch compare selection, or funct3/funct7
// decode for register and immediate arithmetic.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       opb5,
    output logic [3:0] ALUControl
);

    // Map the ALUOp class and instruction fields to one ALU operation
    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_BRANCH: begin
                case (funct3)
                    3'b100, 3'b101: ALUControl = ALU_SLT;
                    3'b110, 3'b111: ALUControl = ALU_SLTU;
                    default:        ALUControl = ALU_SUB;
                endcase
            end
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only register-register ops can subtract; addi ignores bit 30
                    3'b000:  ALUControl = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  ALUControl = ALU_SLL;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b011:  ALUControl = ALU_SLTU;
                    3'b100:  ALUControl = ALU_XOR;
                    3'b101:  ALUControl = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  ALUControl = ALU_OR;
                    default: ALUControl = ALU_AND;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RV32I main controller. A Moore FSM sequences the shared ALU,
// register file and unified memory port; memory steps hold on mem_ready.
// Memory handshake: mem_req is held high with a stable address/strobe until
// a cycle in which mem_ready=1, which completes the access; mem_ready in any
// cycle without mem_req is ignored.
module mc_controller
    import riscv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic [2:0]  Load,
    output logic [1:0]  Store,
    output logic        illegal
);

    ctrlState_e state;
    ctrlState_e nextState;
    logic       illegalReg;
    logic [1:0] aluOp;
    logic       branchTaken;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unusedInstrBits;

    assign opcode          = Instr[6:0];
    assign funct3          = Instr[14:12];
    assign unusedInstrBits = ^{Instr[31], Instr[29:15], Instr[11:7]};

    // State register and sticky illegal flag, both cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            illegalReg <= 1'b0;
        end else begin
            state <= nextState;
            if (nextState == HALT) begin
                illegalReg <= 1'b1;
            end
        end
    end

    // Branch resolution: the ALU compare result arrives as Zero this cycle
    always_comb begin
        case (funct3)
            3'b000:  branchTaken = Zero;   // beq  (sub)
            3'b001:  branchTaken = !Zero;  // bne  (sub)
            3'b100:  branchTaken = !Zero;  // blt  (slt)
            3'b101:  branchTaken = Zero;   // bge  (slt)
            3'b110:  branchTaken = !Zero;  // bltu (sltu)
            3'b111:  branchTaken = Zero;   // bgeu (sltu)
            default: branchTaken = 1'b0;   // 010/011 are not branches
        endcase
    end

    // Next-state selection
    always_comb begin
        nextState = state;
        case (state)
            FETCH: begin
                if (mem_ready) begin
                    nextState = DECODE;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: nextState = MEMADR;
                    OP_R:              nextState = EXECR;
                    OP_IMM:            nextState = EXECI;
                    OP_BRANCH:         nextState = BRANCH;
                    OP_JAL:            nextState = JAL;
                    OP_JALR:           nextState = JALRADR;
                    OP_LUI:            nextState = LUI;
                    OP_AUIPC:          nextState = ALUWB;
                    default:           nextState = HALT;
                endcase
            end
            MEMADR:   nextState = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD: begin
                if (mem_ready) begin
                    nextState = MEMWB;
                end
            end
            MEMWB:    nextState = FETCH;
            MEMWRITE: begin
                if (mem_ready) begin
                    nextState = FETCH;
                end
            end
            EXECR:    nextState = ALUWB;
            EXECI:    nextState = ALUWB;
            ALUWB:    nextState = FETCH;
            BRANCH:   nextState = (funct3[2:1] == 2'b01) ? HALT : FETCH;
            JAL:      nextState = ALUWB;
            JALRADR:  nextState = JALRPC;
            JALRPC:   nextState = ALUWB;
            LUI:      nextState = FETCH;
            HALT:     nextState = HALT;
            default:  nextState = HALT;
        endcase
    end

    // Datapath controls decoded from the state; enables are masked during reset
    always_comb begin
        mem_req   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ResultSrc = RES_ALUOUT;
        aluOp     = ALUOP_ADD;
        Load      = 3'b000;
        Store     = 2'b00;
        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                Load    = funct3;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                Load      = funct3;
            end
            MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                Store    = funct3[1:0];
            end
            EXECR: begin
                ALUSrcA = SRCA_RS1;
                aluOp   = ALUOP_FUNCT;
            end
            EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                aluOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = SRCA_RS1;
                aluOp   = ALUOP_BRANCH;
                PCWrite = branchTaken;
            end
            JAL, JALRPC: begin
                // PC takes the target held in ALUOut while the ALU forms OldPC+4
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            JALRADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            LUI: begin
                ResultSrc = RES_IMMEXT;
                RegWrite  = 1'b1;
            end
            default: begin
                // HALT: everything idle
            end
        endcase
        if (reset) begin
            mem_req  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign ImmSrc  = immSrcFor(opcode);
    assign illegal = illegalReg;

    alu_decoder uAluDecoder (
        .ALUOp      (aluOp),
        .funct3     (funct3),
        .funct7b5   (Instr[30]),
        .opb5       (Instr[5]),
        .ALUControl (ALUControl)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller. Each instruction is turned into an
// expected per-cycle timeline of control outputs (one packed word per cycle),
// built from the instruction class, the wait states chosen for it and, for
// branches, the architectural compare of two operand values.
module tb_mc_controller;

    localparam int W = 25;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic        Zero;
    logic        mem_ready;
    logic        mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0]  ImmSrc;
    logic [3:0]  ALUControl;
    logic [2:0]  Load;
    logic [1:0]  Store;
    logic        illegal;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [W-1:0] exp_q[$];
    bit           rdy_q[$];
    logic [31:0]  cur_instr;
    logic         cur_zero;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .Load       (Load),
        .Store      (Store),
        .illegal    (illegal)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            OPC_STORE:          return 3'b001;
            OPC_BRANCH:         return 3'b010;
            OPC_LUI, OPC_AUIPC: return 3'b011;
            OPC_JAL:            return 3'b100;
            default:            return 3'b000;
        endcase
    endfunction

    // ALU operation named by an R-type / OP-IMM instruction
    function automatic logic [3:0] funct_op(input logic [31:0] ins);
        case (ins[14:12])
            3'b000:  return (ins[6:0] == OPC_R && ins[30]) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ins[30] ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // en = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite}
    function automatic logic [W-1:0] vec(input logic [5:0] en, input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] res, input logic [3:0] alu,
                                         input logic [2:0] ld, input logic [1:0] st);
        return {en, a, b, res, alu, ld, st, imm_of(cur_instr[6:0]), 1'b0};
    endfunction

    function automatic logic [W-1:0] obs();
        return {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
                ResultSrc, ALUControl, Load, Store, ImmSrc, illegal};
    endfunction

    function automatic void push(input logic [W-1:0] v, input bit rdy);
        exp_q.push_back(v);
        rdy_q.push_back(rdy);
    endfunction

    // Cycle without a memory request: mem_ready is random noise
    function automatic void push_any(input logic [W-1:0] v);
        push(v, 1'($urandom_range(0, 1)));
    endfunction

    // Expected timeline of one instruction; fw/mw are wait cycles on fetch and data access
    task automatic build(input logic [31:0] ins, input int fw, input int mw,
                         input logic [31:0] opa, input logic [31:0] opb, input int halt_cycles);
        logic [6:0]   op;
        logic [2:0]   f3;
        logic         taken;
        logic         lt;
        logic [3:0]   cmp;
        logic [W-1:0] wb;
        cur_instr = ins;
        cur_zero  = 1'($urandom_range(0, 1));
        op = ins[6:0];
        f3 = ins[14:12];
        wb = vec(6'b000001, 2'b00, 2'b00, 2'b00, ALU_ADD, 3'b000, 2'b00);
        for (int i = 0; i < fw; i++) push(vec(6'b100000, 2'b00, 2'b10, 2'b10, ALU_ADD, 3'b000, 2'b00), 1'b0);
        push(vec(6'b100110, 2'b00, 2'b10, 2'b10, ALU_ADD, 3'b000, 2'b00), 1'b1);
        push_any(vec(6'b000000, 2'b01, 2'b01, 2'b00, ALU_ADD, 3'b000, 2'b00));
        case (op)
            OPC_LOAD: begin
                push_any(vec(6'b000000, 2'b10, 2'b01, 2'b00, ALU_ADD, 3'b000, 2'b00));
                for (int i = 0; i < mw; i++) push(vec(6'b110000, 2'b00, 2'b00, 2'b00, ALU_ADD, f3, 2'b00), 1'b0);
                push(vec(6'b110000, 2'b00, 2'b00, 2'b00, ALU_ADD, f3, 2'b00), 1'b1);
                push_any(vec(6'b000001, 2'b00, 2'b00, 2'b01, ALU_ADD, f3, 2'b00));
            end
            OPC_STORE: begin
                push_any(vec(6'b000000, 2'b10, 2'b01, 2'b00, ALU_ADD, 3'b000, 2'b00));
                for (int i = 0; i < mw; i++) push(vec(6'b111000, 2'b00, 2'b00, 2'b00, ALU_ADD, 3'b000, f3[1:0]), 1'b0);
                push(vec(6'b111000, 2'b00, 2'b00, 2'b00, ALU_ADD, 3'b000, f3[1:0]), 1'b1);
            end
            OPC_R: begin
                push_any(vec(6'b000000, 2'b10, 2'b00, 2'b00, funct_op(ins), 3'b000, 2'b00));
                push_any(wb);
            end
            OPC_IMM: begin
                push_any(vec(6'b000000, 2'b10, 2'b01, 2'b00, funct_op(ins), 3'b000, 2'b00));
                push_any(wb);
            end
            OPC_AUIPC: push_any(wb);
            OPC_LUI:   push_any(vec(6'b000001, 2'b00, 2'b00, 2'b11, ALU_ADD, 3'b000, 2'b00));
            OPC_BRANCH: begin
                case (f3)
                    3'b000, 3'b001: begin
                        cmp = ALU_SUB;
                        cur_zero = ((opa - opb) == 32'd0);
                        taken = (f3 == 3'b000) ? (opa == opb) : (opa != opb);
                    end
                    3'b100, 3'b101: begin
                        cmp = ALU_SLT;
                        lt = ($signed(opa) < $signed(opb));
                        cur_zero = !lt;
                        taken = (f3 == 3'b100) ? lt : !lt;
                    end
                    default: begin
                        cmp = ALU_SLTU;
                        lt = (opa < opb);
                        cur_zero = !lt;
                        taken = (f3 == 3'b110) ? lt : !lt;
                    end
                endcase
                push_any(vec({4'b0000, taken, 1'b0}, 2'b10, 2'b00, 2'b00, cmp, 3'b000, 2'b00));
            end
            OPC_JAL: begin
                push_any(vec(6'b000010, 2'b01, 2'b10, 2'b00, ALU_ADD, 3'b000, 2'b00));
                push_any(wb);
            end
            OPC_JALR: begin
                push_any(vec(6'b000000, 2'b10, 2'b01, 2'b00, ALU_ADD, 3'b000, 2'b00));
                push_any(vec(6'b000010, 2'b01, 2'b10, 2'b00, ALU_ADD, 3'b000, 2'b00));
                push_any(wb);
            end
            default: begin
                for (int i = 0; i < halt_cycles; i++)
                    push_any(vec(6'b000000, 2'b00, 2'b00, 2'b00, ALU_ADD, 3'b000, 2'b00) | W'(1));
            end
        endcase
    endtask

    // ---------------- driver + scoreboard ----------------
    // Entered and left just after a rising edge; checks each cycle at the falling edge
    task automatic run_queue(input string name, input int max_cycles);
        int n;
        logic [W-1:0] e;
        n = 0;
        while (exp_q.size() > 0 && n < max_cycles) begin
            e         = exp_q.pop_front();
            Instr     = cur_instr;
            Zero      = cur_zero;
            mem_ready = rdy_q.pop_front();
            @(negedge clk);
            tests_run++;
            if (obs() !== e) begin
                tests_failed++;
                $display("FAIL %s cycle %0d instr %h: got %h expected %h", name, n, cur_instr, obs(), e);
            end
            @(posedge clk);
            #1;
            n++;
        end
        exp_q.delete();
        rdy_q.delete();
    endtask

    task automatic do_reset(input int cycles, input logic rdy);
        reset     = 1'b1;
        mem_ready = rdy;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            tests_run++;
            if ({mem_req, MemWrite, IRWrite, PCWrite, RegWrite} !== 5'b00000) begin
                tests_failed++;
                $display("FAIL reset_enables cycle %0d: got %b expected 00000", i,
                         {mem_req, MemWrite, IRWrite, PCWrite, RegWrite});
            end
            if (i > 0) begin
                tests_run++;
                if (illegal !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL reset_illegal cycle %0d: got %b expected 0", i, illegal);
                end
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset(3, 1'b1);
    endtask

    task automatic test_addi();
        build(32'h00500093, 0, 0, 0, 0, 0);
        run_queue("addi", 100);
    endtask

    task automatic test_load_wait();
        build(mk(7'h00, 5'd0, 5'd2, 3'b010, 5'd1, OPC_LOAD), 0, 3, 0, 0, 0);
        run_queue("lw_wait", 100);
        build(mk(7'h00, 5'd3, 5'd2, 3'b001, 5'd0, OPC_STORE), 2, 2, 0, 0, 0);
        run_queue("sh_wait", 100);
    endtask

    task automatic test_alu_decode();
        build(mk(7'h20, 5'd2, 5'd1, 3'b000, 5'd1, OPC_R), 0, 0, 0, 0, 0);
        run_queue("sub", 100);
        build(mk(7'h20, 5'd3, 5'd1, 3'b101, 5'd1, OPC_IMM), 0, 0, 0, 0, 0);
        run_queue("srai", 100);
        build(mk(7'h20, 5'd0, 5'd1, 3'b000, 5'd1, OPC_IMM), 0, 0, 0, 0, 0);
        run_queue("addi_b30", 100);
        for (int f = 0; f < 8; f++) begin
            build(mk({1'b0, 1'($urandom_range(0, 1)), 5'd0}, 5'd4, 5'd5, 3'(f), 5'd6, OPC_R), 0, 0, 0, 0, 0);
            run_queue("rtype_f3", 100);
        end
    endtask

    task automatic test_branch();
        build(mk(7'h00, 5'd2, 5'd1, 3'b001, 5'd0, OPC_BRANCH), 0, 0, 32'd5, 32'd7, 0);
        run_queue("bne_taken", 100);
        build(mk(7'h00, 5'd2, 5'd1, 3'b001, 5'd0, OPC_BRANCH), 0, 0, 32'd9, 32'd9, 0);
        run_queue("bne_not_taken", 100);
        build(mk(7'h00, 5'd2, 5'd1, 3'b111, 5'd0, OPC_BRANCH), 0, 0, 32'd9, 32'd9, 0);
        run_queue("bgeu_equal", 100);
        build(mk(7'h00, 5'd2, 5'd1, 3'b100, 5'd0, OPC_BRANCH), 0, 0, 32'h80000000, 32'd1, 0);
        run_queue("blt_signed", 100);
        build(mk(7'h00, 5'd2, 5'd1, 3'b110, 5'd0, OPC_BRANCH), 0, 0, 32'h80000000, 32'd1, 0);
        run_queue("bltu_unsigned", 100);
        build(mk(7'h00, 5'd2, 5'd1, 3'b101, 5'd0, OPC_BRANCH), 0, 0, 32'hFFFFFFFF, 32'd0, 0);
        run_queue("bge_negative", 100);
    endtask

    task automatic test_jumps();
        build(mk(7'h00, 5'd0, 5'd1, 3'b000, 5'd1, OPC_JALR), 0, 0, 0, 0, 0);
        run_queue("jalr", 100);
        build(32'h0080006F, 1, 0, 0, 0, 0);
        run_queue("jal", 100);
        build(32'h123450B7, 0, 0, 0, 0, 0);
        run_queue("lui", 100);
        build(32'h00001097, 0, 0, 0, 0, 0);
        run_queue("auipc", 100);
    endtask

    task automatic test_halt();
        build(32'h0000007F, 0, 0, 0, 0, 8);
        run_queue("halt", 100);
        do_reset(2, 1'b0);
        build(32'h00500093, 0, 0, 0, 0, 0);
        run_queue("after_halt", 100);
    endtask

    task automatic test_reset_abort();
        build(mk(7'h00, 5'd3, 5'd2, 3'b010, 5'd0, OPC_STORE), 0, 3, 0, 0, 0);
        run_queue("sw_abort", 4);
        do_reset(2, 1'b1);
        build(mk(7'h00, 5'd0, 5'd2, 3'b100, 5'd1, OPC_LOAD), 0, 3, 0, 0, 0);
        run_queue("lbu_abort", 5);
        do_reset(2, 1'b1);
        build(32'h00500093, 0, 0, 0, 0, 0);
        run_queue("after_abort", 100);
    endtask

    task automatic test_back_to_back();
        logic [6:0]  ops [9];
        logic [2:0]  br_f3 [6];
        logic [31:0] ins, a, b;
        ops   = '{OPC_LOAD, OPC_STORE, OPC_R, OPC_IMM, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};
        br_f3 = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        for (int k = 0; k < 150; k++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 8)];
            if (ins[6:0] == OPC_BRANCH) ins[14:12] = br_f3[$urandom_range(0, 5)];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
            build(ins, $urandom_range(0, 2), $urandom_range(0, 3), a, b, 0);
            run_queue("back_to_back", 100);
        end
    endtask

    initial begin
        reset     = 1'b1;
        Instr     = 32'h00000013;
        Zero      = 1'b0;
        mem_ready = 1'b0;
        cur_instr = 32'h00000013;
        cur_zero  = 1'b0;
        #1;
        test_reset();
        test_addi();
        test_load_wait();
        test_alu_decode();
        test_branch();
        test_jumps();
        test_halt();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle main controller for the RV32I core. It sequences one shared ALU, register file and unified instruction/data memory port through fetch, decode, execute, memory and writeback steps. It drives every enable and mux select of the multi-cycle datapath from a Moore state machine plus combinational ALU/immediate decode. It stalls on a ready/request handshake with memory and latches a sticky illegal-instruction halt.

## Interface
Parameters:
- none; all encodings are fixed constants in the shared package.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `Instr`  in  32  instruction register contents.
- `Zero`  in  1  ALU zero flag, same cycle.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access requested.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemWrite`  out  1  store strobe.
- `IRWrite`  out  1  load IR and OldPC.
- `PCWrite`  out  1  load PC from Result.
- `RegWrite`  out  1  register file write enable.
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB`  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- `ResultSrc`  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt.
- `ImmSrc`  out  3  immediate format: I = 000, S = 001, B = 010, U = 011, J = 100.
- `ALUControl`  out  4  ALU operation: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110, sll 0111, srl 1000, sra 1001.
- `Load`  out  3  equals `Instr[14:12]` in MEMREAD/MEMWB, else 000.
- `Store`  out  2  equals `Instr[13:12]` in MEMWRITE, else 00.
- `illegal`  out  1  sticky halt flag.

## Operation
- States (4-bit): FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALRADR, JALRPC, LUI, HALT.
- **FETCH**
  - Drives: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite and PCWrite are asserted only in the cycle where mem_ready=1. Without mem_ready, stay in FETCH.
- **DECODE**
  - Drives: ALUSrcA=01, ALUSrcB=01, add. ALUOut becomes OldPC+imm.
  - Next state by opcode:
    - load or store → MEMADR
    - R-type (0110011) → EXECR
    - OP-IMM (0010011) → EXECI
    - branch → BRANCH
    - jal → JAL
    - jalr → JALRADR
    - lui → LUI
    - auipc → ALUWB
    - any other opcode → HALT
- **MEMADR**: ALUSrcA=10, ALUSrcB=01, add. Next is MEMREAD for loads, MEMWRITE for stores.
- **MEMREAD**: mem_req=1, AdrSrc=1; hold until mem_ready, then MEMWB.
- **MEMWB**: ResultSrc=01, RegWrite=1.
- **MEMWRITE**: mem_req=1, AdrSrc=1, MemWrite=1; hold until mem_ready, then FETCH.
- **EXECR**: ALUSrcA=10, ALUSrcB=00, funct decode. Next is ALUWB.
- **EXECI**: ALUSrcA=10, ALUSrcB=01, funct decode. Next is ALUWB.
- **ALUWB**: ResultSrc=00, RegWrite=1. Next is FETCH.
- **BRANCH**
  - Drives: ALUSrcA=10, ALUSrcB=00, ResultSrc=00.
  - ALU op and taken condition by funct3:
    - beq: sub, taken if Zero.
    - bne: sub, taken if !Zero.
    - blt: slt, taken if !Zero.
    - bge: slt, taken if Zero.
    - bltu: sltu, taken if !Zero.
    - bgeu: sltu, taken if Zero.
  - PCWrite = taken. Next is FETCH.
  - funct3 010 or 011 → HALT.
- **JAL**: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next is ALUWB, which writes OldPC+4.
- **JALRADR**: ALUSrcA=10, ALUSrcB=01, add. Next is JALRPC.
- **JALRPC**: ResultSrc=00, PCWrite=1, ALUSrcA=01, ALUSrcB=10, add. Next is ALUWB.
- **LUI**: ResultSrc=11, RegWrite=1. Next is FETCH.
- **HALT**
  - illegal=1. All enables and mem_req are 0.
  - Only reset leaves HALT.
- **Funct decode**
  - Operation comes from funct3.
  - sub when R-type, funct3=000 and funct7[5]=1. OP-IMM funct3=000 is always add.
  - funct3=101 with funct7[5]=1 → sra.
- **ImmSrc** is decoded from opcode in every state; it is don't-care for R-type.
- All select outputs not listed for a state are 00. All enables not listed are 0.

## Timing
- Outputs are Moore, decoded from the state register. The only exceptions are:
  - IRWrite and PCWrite in FETCH, qualified by mem_ready;
  - PCWrite in BRANCH, qualified by Zero.
- Reset:
  - Sampled on the clock edge; the state register goes to FETCH and illegal clears.
  - While reset is high, mem_req, MemWrite, IRWrite, PCWrite and RegWrite are forced to 0.
  - The first fetch request appears in the first cycle after reset deasserts.
  - Reset mid-access (MEMREAD, MEMWRITE, any state) aborts immediately; no write enable fires in the reset cycle.
- Cycles per instruction with zero wait states:
  - lui 3, auipc 3, branch 3
  - R-type 4, OP-IMM 4, store 4, jal 4
  - load 5, jalr 5
- Each cycle of mem_ready=0 adds one cycle. mem_req stays asserted and AdrSrc, MemWrite, Load and Store stay stable while waiting.
- mem_ready arriving in a state without mem_req is ignored.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - opcode constants;
  - state enum;
  - ALUControl codes;
  - ImmSrc, ResultSrc and ALUSrc encodings.
- Sub-module `alu_decoder` (combinational) has:
  - inputs: ALUOp (00 add, 01 branch compare, 10 funct decode), funct3, funct7[5], opcode[5];
  - output: ALUControl.
- The FSM and branch-taken logic stay in `mc_controller`.

## Test plan
- Reset, then `addi x1,x0,5` (0x00500093) with mem_ready=1 → states FETCH, DECODE, EXECI, ALUWB. RegWrite=1 in cycle 4 with ResultSrc=00, ALUControl=0000.
- `lw` with mem_ready low for 3 cycles in MEMREAD → mem_req and AdrSrc=1 held for 4 cycles, Load=010. MEMWB RegWrite=1 arrives 8 cycles after fetch start.
- `sub` (funct7=0100000) → ALUControl=0001 in EXECR. `srai` → 1001. `addi` with Instr[30]=1 → 0000.
- `bne` with Zero=0 → PCWrite=1 in BRANCH, next state FETCH. With Zero=1 → PCWrite=0. `bgeu` with Zero=1 → taken, ALUControl=0110.
- `jalr` → JALRADR then JALRPC (PCWrite=1, ResultSrc=00), then ALUWB (RegWrite=1). Total 5 cycles.
- Opcode 0x7F → HALT, illegal=1, all enables 0 indefinitely. Reset asserted → FETCH and illegal=0 on the next edge.
